lfsr_period_checker: RTL and testbench
======================================

LFSR_PERIOD_CHECKER -- requirements
Module: lfsr_period_checker

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 3 bits and the sequence buffer at 8 entries.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 set  input  1  asynchronous, active-high reset; clears all state and outputs.
REQ-004 en  input  1  sample strobe; din is consumed on a rising clk edge only when en=1.
REQ-005 din  input  3  LFSR output value under test.
REQ-006 period  output  4  measured sequence period, 1..8; 0 until measured.
REQ-007 done  output  1  period measurement complete.
REQ-008 maximal  output  1  period is 7 and value 000 was never seen.
REQ-009 lockup  output  1  LFSR stuck at 000 (period 1 with reference 000).
REQ-010 err  output  1  sticky sequence fault.
REQ-011 pass_cnt  output  4  count of fully verified periods after measurement, saturating at 15.

Function
REQ-012 All outputs SHALL be registered, and every state change SHALL occur on a rising clk edge with en=1; with en=0, all state SHALL hold.
REQ-013 The FSM SHALL have exactly four states: IDLE, MEASURE, VERIFY, FAIL.
REQ-014 In IDLE, on a sample, the block SHALL store ref=din, seq[0]=din, seen[din]=1, idx=1, and go to MEASURE.
REQ-015 In MEASURE, if din==ref, the block SHALL set period=idx and done=1, set pos=(idx==1)?0:1, and go to VERIFY, all on that same edge.
REQ-016 In MEASURE, if din!=ref and seen[din]=1, the block SHALL set err=1 and go to FAIL (non-cyclic sequence).
REQ-017 Otherwise in MEASURE, the block SHALL set seq[idx]=din and seen[din]=1, and increment idx; idx never exceeds 8 because seen[] blocks repeats.
REQ-018 A sample that returns to ref while the block is in MEASURE SHALL take priority over the seen[] check.
REQ-019 On entry to VERIFY, maximal SHALL be set to 1 if period==7 and seen[0]==0; lockup SHALL be set to 1 if period==1 and ref==000.
REQ-020 In VERIFY, if din!=seq[pos], the block SHALL set err=1 and go to FAIL; done, period, maximal and lockup SHALL retain their values.
REQ-021 In VERIFY, if din==seq[pos], the block SHALL set pos=(pos+1==period)?0:pos+1.
REQ-022 When pos wraps to 0, pass_cnt SHALL increment, saturating at 15.
REQ-023 For period 1, every matching sample SHALL count as a wrap.
REQ-024 FAIL SHALL be terminal: samples are ignored and err stays at 1 until set is asserted.
REQ-025 Wrap-around of the pos index SHALL use period as the modulus; seq entries at and above period SHALL never be read in VERIFY.

Reset
REQ-026 Asserting set SHALL immediately clear period, done, maximal, lockup, err, pass_cnt, seen[], idx, pos and ref to 0, and force the FSM to IDLE, independent of clk.
REQ-027 The contents of the seq[] buffer need not be reset.
REQ-028 Asserting set mid-MEASURE or mid-VERIFY SHALL discard all progress; the first en sample after set deasserts SHALL become the new ref.
REQ-029 Releasing set SHALL take effect on the next rising edge, with no extra latency cycles.

Verification
REQ-030 Reset: the bench SHALL drive set=1 with any din/en and check that all outputs are 0 with no clk edge required.
REQ-031 Maximal LFSR: the bench SHALL feed din 1,4,6,7,3,5,2,1 with en=1 and check that done=1, period=7, maximal=1 and lockup=0 after the 8th edge; after 14 more correct samples it SHALL check pass_cnt=2 and err=0.
REQ-032 Lockup: the bench SHALL feed din 0,0 and check that done=1, period=1, lockup=1 and maximal=0 after the 2nd edge; after 20 further 0 samples it SHALL check pass_cnt=15 (saturated).
REQ-033 Non-cyclic: the bench SHALL feed din 1,4,6,4 and check that err=1, done=0 and period=0 after the 4th edge; further samples SHALL leave all outputs unchanged.
REQ-034 Verify fault: the bench SHALL measure 1,4,6,7,3,5,2,1, then feed 4,6,0, and check that err=1 while done=1, period=7 and maximal=1 are retained, with pass_cnt=0.
REQ-035 Gaps and mid-run reset: the bench SHALL repeat REQ-031 with en toggling every cycle and check identical results; it SHALL then pulse set after 1,4,6, feed 5,2,5, and check that period=2.

Source files
------------

// File: rtl/lfsr_period_checker.sv
// lfsr_period_checker: measures the period of a 3-bit LFSR stream.
// It then re-verifies every later period against the captured sequence.
//
// Ports:
//   clk      rising-edge clock for all state
//   set      asynchronous active-high reset
//   en       sample strobe; din is consumed on a clk edge only when en=1
//   din      3-bit LFSR output under test
//   period   measured period 1..8, 0 until it has been measured
//   done     period measurement complete
//   maximal  period is 7 and value 000 never appeared
//   lockup   stream stuck at 000 (period 1, reference 000)
//   err      sticky sequence fault
//   pass_cnt fully verified periods after measurement, saturating at 15
module lfsr_period_checker (
    input  logic       clk,
    input  logic       set,
    input  logic       en,
    input  logic [2:0] din,
    output logic [3:0] period,
    output logic       done,
    output logic       maximal,
    output logic       lockup,
    output logic       err,
    output logic [3:0] pass_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_VERIFY  = 2'd2;
    localparam logic [1:0] ST_FAIL    = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] ref_q, ref_d;
    logic [7:0] seen_q, seen_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] pos_q, pos_d;
    logic [3:0] period_q, period_d;
    logic       done_q, done_d;
    logic       maximal_q, maximal_d;
    logic       lockup_q, lockup_d;
    logic       err_q, err_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic [2:0] seq_q [8];
    logic [2:0] seq_d [8];
    logic [3:0] pos_nxt;

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        seen_d     = seen_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        period_d   = period_q;
        done_d     = done_q;
        maximal_d  = maximal_q;
        lockup_d   = lockup_q;
        err_d      = err_q;
        pass_cnt_d = pass_cnt_q;
        seq_d      = seq_q;
        pos_nxt    = {1'b0, pos_q} + 4'd1;

        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    ref_d       = din;
                    seq_d[0]    = din;
                    seen_d[din] = 1'b1;
                    idx_d       = 4'd1;
                    state_d     = ST_MEASURE;
                end
                ST_MEASURE: begin
                    // Returning to the reference wins over the repeat check.
                    if (din == ref_q) begin
                        period_d  = idx_q;
                        done_d    = 1'b1;
                        pos_d     = (idx_q == 4'd1) ? 3'd0 : 3'd1;
                        maximal_d = (idx_q == 4'd7) && !seen_q[0];
                        lockup_d  = (idx_q == 4'd1) && (ref_q == 3'd0);
                        state_d   = ST_VERIFY;
                    end else if (seen_q[din]) begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end else begin
                        // idx stays <= 7 here: 8 distinct values
                        // already seen means every din hits a branch above.
                        seq_d[idx_q[2:0]] = din;
                        seen_d[din]       = 1'b1;
                        idx_d             = idx_q + 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (din != seq_q[pos_q]) begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end else if (pos_nxt == period_q) begin
                        // Wrap; for period 1 every match lands here.
                        pos_d = 3'd0;
                        if (pass_cnt_q != 4'd15) begin
                            pass_cnt_d = pass_cnt_q + 4'd1;
                        end
                    end else begin
                        pos_d = pos_nxt[2:0];
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            state_q    <= ST_IDLE;
            ref_q      <= 3'd0;
            seen_q     <= 8'd0;
            idx_q      <= 4'd0;
            pos_q      <= 3'd0;
            period_q   <= 4'd0;
            done_q     <= 1'b0;
            maximal_q  <= 1'b0;
            lockup_q   <= 1'b0;
            err_q      <= 1'b0;
            pass_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            seen_q     <= seen_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            period_q   <= period_d;
            done_q     <= done_d;
            maximal_q  <= maximal_d;
            lockup_q   <= lockup_d;
            err_q      <= err_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // Sequence buffer is only read behind valid state, so it is not reset.
    always_ff @(posedge clk) begin
        seq_q <= seq_d;
    end

    assign period   = period_q;
    assign done     = done_q;
    assign maximal  = maximal_q;
    assign lockup   = lockup_q;
    assign err      = err_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// tb_lfsr_period_checker: directed and random stimulus for the checker.
// Expected outputs come from a history-based model of the sample stream.
module tb_lfsr_period_checker;

    logic       clk = 1'b0;
    logic       set;
    logic       en;
    logic [2:0] din;
    logic [3:0] period;
    logic       done;
    logic       maximal;
    logic       lockup;
    logic       err;
    logic [3:0] pass_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] hist [$];
    logic [2:0] mseq [8] = '{3'd1, 3'd4, 3'd6, 3'd7, 3'd3, 3'd5, 3'd2, 3'd1};

    lfsr_period_checker dut (
        .clk      (clk),
        .set      (set),
        .en       (en),
        .din      (din),
        .period   (period),
        .done     (done),
        .maximal  (maximal),
        .lockup   (lockup),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs derived from the whole sample history since reset.
    task automatic model_eval(output int p, output int d, output int mx,
                              output int lk, output int er, output int pc);
        int n;
        int j;
        bool_dup: begin end
        n  = hist.size();
        p  = 0; d = 0; mx = 0; lk = 0; er = 0; pc = 0;
        j  = -1;
        for (int k = 1; k < n; k++) begin
            if (hist[k] == hist[0]) begin
                j = k;
                break;
            end
            for (int m = 0; m < k; m++) begin
                if (hist[m] == hist[k]) er = 1;
            end
            if (er != 0) break;
        end
        if (j < 0) return;
        p  = j;
        d  = 1;
        mx = (p == 7) ? 1 : 0;
        for (int m = 0; m < p; m++) begin
            if (hist[m] == 3'd0) mx = 0;
        end
        lk = (p == 1 && hist[0] == 3'd0) ? 1 : 0;
        for (int k = j + 1; k < n; k++) begin
            if (hist[k] != hist[k % p]) begin
                er = 1;
                break;
            end
            if ((k + 1) % p == 0 && pc < 15) pc++;
        end
    endtask

    task automatic compare_all(input string tag);
        int p, d, mx, lk, er, pc;
        model_eval(p, d, mx, lk, er, pc);
        check({tag, ".period"},   int'(period),   p);
        check({tag, ".done"},     int'(done),     d);
        check({tag, ".maximal"},  int'(maximal),  mx);
        check({tag, ".lockup"},   int'(lockup),   lk);
        check({tag, ".err"},      int'(err),      er);
        check({tag, ".pass_cnt"}, int'(pass_cnt), pc);
    endtask

    // Starts and ends on a negedge; outputs checked with no clk edge.
    task automatic pulse_set();
        set = 1'b1;
        en  = 1'($urandom);
        din = 3'($urandom);
        hist.delete();
        #1;
        compare_all("rst");
        @(negedge clk);
        set = 1'b0;
        en  = 1'b0;
    endtask

    task automatic cyc(input logic e, input logic [2:0] d, input string tag);
        en  = e;
        din = d;
        @(posedge clk);
        if (e) hist.push_back(d);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        int perm [8];
        int p;
        int ns;
        int t;
        int sw;
        logic [2:0] v;

        set = 1'b1;
        en  = 1'b0;
        din = 3'd0;
        pulse_set();

        // Maximal-length stream
        for (int i = 0; i < 8; i++) cyc(1'b1, mseq[i], "max");
        check("max.done", int'(done), 1);
        check("max.period", int'(period), 7);
        check("max.maximal", int'(maximal), 1);
        check("max.lockup", int'(lockup), 0);
        for (int i = 0; i < 14; i++) cyc(1'b1, mseq[(i + 1) % 7], "maxv");
        check("max.pass_cnt", int'(pass_cnt), 2);
        check("max.err", int'(err), 0);

        // Lockup at 000
        pulse_set();
        cyc(1'b1, 3'd0, "lk");
        cyc(1'b1, 3'd0, "lk");
        check("lk.done", int'(done), 1);
        check("lk.period", int'(period), 1);
        check("lk.lockup", int'(lockup), 1);
        check("lk.maximal", int'(maximal), 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 3'd0, "lkv");
        check("lk.pass_cnt", int'(pass_cnt), 15);

        // Non-cyclic stream
        pulse_set();
        cyc(1'b1, 3'd1, "nc");
        cyc(1'b1, 3'd4, "nc");
        cyc(1'b1, 3'd6, "nc");
        cyc(1'b1, 3'd4, "nc");
        check("nc.err", int'(err), 1);
        check("nc.done", int'(done), 0);
        check("nc.period", int'(period), 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 3'($urandom), "nc_hold");
        check("nc_hold.err", int'(err), 1);
        check("nc_hold.period", int'(period), 0);

        // Fault during verification
        pulse_set();
        for (int i = 0; i < 8; i++) cyc(1'b1, mseq[i], "vf");
        cyc(1'b1, 3'd4, "vf");
        cyc(1'b1, 3'd6, "vf");
        cyc(1'b1, 3'd0, "vf");
        check("vf.err", int'(err), 1);
        check("vf.done", int'(done), 1);
        check("vf.period", int'(period), 7);
        check("vf.maximal", int'(maximal), 1);
        check("vf.pass_cnt", int'(pass_cnt), 0);

        // Maximal stream with en toggling every cycle
        pulse_set();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, mseq[i], "gap");
            cyc(1'b0, 3'($urandom), "gap");
        end
        check("gap.done", int'(done), 1);
        check("gap.period", int'(period), 7);
        check("gap.maximal", int'(maximal), 1);
        check("gap.lockup", int'(lockup), 0);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, mseq[(i + 1) % 7], "gapv");
            cyc(1'b0, 3'($urandom), "gapv");
        end
        check("gap.pass_cnt", int'(pass_cnt), 2);
        check("gap.err", int'(err), 0);

        // Reset in the middle of a measurement
        pulse_set();
        cyc(1'b1, 3'd1, "mr");
        cyc(1'b1, 3'd4, "mr");
        cyc(1'b1, 3'd6, "mr");
        pulse_set();
        cyc(1'b1, 3'd5, "mr2");
        cyc(1'b1, 3'd2, "mr2");
        cyc(1'b1, 3'd5, "mr2");
        check("mr.period", int'(period), 2);
        check("mr.done", int'(done), 1);

        // Random periodic streams with gaps, faults and resets
        for (int r = 0; r < 60; r++) begin
            pulse_set();
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                sw = int'($urandom_range(0, i));
                t = perm[i];
                perm[i] = perm[sw];
                perm[sw] = t;
            end
            p  = int'($urandom_range(1, 8));
            ns = int'($urandom_range(4, 40));
            for (int k = 0; k < ns; k++) begin
                v = 3'(perm[k % p]);
                if ($urandom_range(0, 24) == 0) v = 3'($urandom);
                if ($urandom_range(0, 59) == 0) pulse_set();
                cyc(($urandom_range(0, 3) != 0), v, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
